seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display. It accepts a 32-bit hex value with per-digit blank and decimal-point masks over a valid/ready handshake. It sequences one digit at a time through the hex2seg decoder and drives active-low segment and anode lines. New data is committed only at a frame boundary, so a refresh never shows a torn value.

---
 rtl/seg7_pkg.sv | 15 +
 rtl/hex2seg.sv | 29 ++
 rtl/seg7_scan_tick.sv | 30 +++
 rtl/seg7_scan_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 8-digit 7-segment scan controller.
package seg7_pkg;

    localparam int NDIG = 8;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF = 8'hFF;

    typedef logic [2:0] digit_idx_t;
    typedef logic [7:0] seg_t;

    function automatic logic [3:0] nibble_of(input logic [31:0] data, input digit_idx_t idx);
        return data[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/hex2seg.sv
// Hex nibble to active-high segment pattern {a,b,c,d,e,f,g,dp}; dp bit is always 0.
module hex2seg (
    input  logic [3:0] hex_i,
    output logic [7:0] seg_o
);

    always_comb begin
        case (hex_i)
            4'h0:    seg_o = 8'hFC;
            4'h1:    seg_o = 8'h60;
            4'h2:    seg_o = 8'hDA;
            4'h3:    seg_o = 8'hF2;
            4'h4:    seg_o = 8'h66;
            4'h5:    seg_o = 8'hB6;
            4'h6:    seg_o = 8'hBE;
            4'h7:    seg_o = 8'hE0;
            4'h8:    seg_o = 8'hFE;
            4'h9:    seg_o = 8'hF6;
            4'hA:    seg_o = 8'hEE;
            4'hB:    seg_o = 8'h3E;
            4'hC:    seg_o = 8'h9C;
            4'hD:    seg_o = 8'h7A;
            4'hE:    seg_o = 8'h9E;
            4'hF:    seg_o = 8'h8E;
            default: seg_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/seg7_scan_tick.sv
// Digit-slot divider: tick_o is high for the one cycle where the counter sits at SCAN_DIV-1.
module seg7_scan_tick #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned DIV_W    = 20
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign tick_o = (div_q == DIV_LAST);

    always_comb begin
        div_d = tick_o ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit common-anode scan controller with frame-boundary commit.
// Optional blink support is compiled in when SEG7_BLINK_EN is defined.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned DIV_W    = 20
`ifdef SEG7_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES = 256
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_blank,
    input  logic [7:0]  wr_dp,
`ifdef SEG7_BLINK_EN
    input  logic [7:0]  wr_blink,
`endif
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic        frame_pulse
);

    logic       tick;
    logic       frame_end;
    logic       accept;

    digit_idx_t idx_q, idx_d;
    logic       pend_q, pend_d;
    logic [31:0] pnd_data_q, pnd_data_d;
    logic [7:0]  pnd_blank_q, pnd_blank_d;
    logic [7:0]  pnd_dp_q, pnd_dp_d;
    logic [31:0] act_data_q, act_data_d;
    logic [7:0]  act_blank_q, act_blank_d;
    logic [7:0]  act_dp_q, act_dp_d;

    seg_t        seg_q, seg_d;
    logic [7:0]  an_q, an_d;
    logic        fp_q, fp_d;

    logic [3:0]  nib;
    seg_t        glyph;
    logic        dark;

    seg7_scan_tick #(
        .SCAN_DIV (SCAN_DIV),
        .DIV_W    (DIV_W)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    assign frame_end = tick & (idx_q == digit_idx_t'(NDIG - 1));
    assign accept    = wr_valid & ~pend_q;

`ifdef SEG7_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [7:0]      pnd_blink_q, pnd_blink_d;
    logic [7:0]      act_blink_q, act_blink_d;
    logic [BF_W-1:0] fcnt_q, fcnt_d;
    logic            phase_q, phase_d;

    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (frame_end) begin
            if (fcnt_q == BF_W'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + BF_W'(1);
            end
        end
        pnd_blink_d = pnd_blink_q;
        act_blink_d = act_blink_q;
        if (frame_end && pend_q) begin
            act_blink_d = pnd_blink_q;
        end else if (accept) begin
            pnd_blink_d = wr_blink;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q      <= '0;
            phase_q     <= 1'b0;
            pnd_blink_q <= '0;
            act_blink_q <= '0;
        end else begin
            fcnt_q      <= fcnt_d;
            phase_q     <= phase_d;
            pnd_blink_q <= pnd_blink_d;
            act_blink_q <= act_blink_d;
        end
    end

    assign dark = act_blank_q[idx_q] | (phase_q & act_blink_q[idx_q]);
`else
    assign dark = act_blank_q[idx_q];
`endif

    // Handshake and commit: the pending set only moves to active on the frame-boundary tick.
    always_comb begin
        idx_d       = idx_q;
        pend_d      = pend_q;
        pnd_data_d  = pnd_data_q;
        pnd_blank_d = pnd_blank_q;
        pnd_dp_d    = pnd_dp_q;
        act_data_d  = act_data_q;
        act_blank_d = act_blank_q;
        act_dp_d    = act_dp_q;

        if (tick) begin
            idx_d = idx_q + 3'd1;
        end

        if (frame_end && pend_q) begin
            act_data_d  = pnd_data_q;
            act_blank_d = pnd_blank_q;
            act_dp_d    = pnd_dp_q;
            pend_d      = 1'b0;
        end else if (accept) begin
            pnd_data_d  = wr_data;
            pnd_blank_d = wr_blank;
            pnd_dp_d    = wr_dp;
            pend_d      = 1'b1;
        end
    end

    assign nib = nibble_of(act_data_q, idx_q);

    hex2seg u_dec (
        .hex_i (nib),
        .seg_o (glyph)
    );

    always_comb begin
        fp_d = frame_end;
        if (dark) begin
            seg_d = SEG_OFF;
            an_d  = AN_OFF;
        end else begin
            seg_d = ~((glyph & 8'hFE) | {7'd0, act_dp_q[idx_q]});
            an_d  = ~(8'b1 << idx_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            pend_q      <= 1'b0;
            pnd_data_q  <= '0;
            pnd_blank_q <= '0;
            pnd_dp_q    <= '0;
            act_data_q  <= '0;
            act_blank_q <= '0;
            act_dp_q    <= '0;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
            fp_q        <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pnd_data_q  <= pnd_data_d;
            pnd_blank_q <= pnd_blank_d;
            pnd_dp_q    <= pnd_dp_d;
            act_data_q  <= act_data_d;
            act_blank_q <= act_blank_d;
            act_dp_q    <= act_dp_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            fp_q        <= fp_d;
        end
    end

    assign wr_ready    = ~pend_q;
    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_pulse = fp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (SCAN_DIV=4): directed table, corner sequences, random traffic.
module tb_seg7_scan_ctrl;

    localparam int SD = 4;
    localparam int FRAME = SD * 8;
`ifdef SEG7_BLINK_EN
    localparam int BF = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] wr_data;
    logic [7:0]  wr_blank;
    logic [7:0]  wr_dp;
    logic [7:0]  wr_blink;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        frame_pulse;

`ifdef SEG7_BLINK_EN
    seg7_scan_ctrl #(.SCAN_DIV(SD), .DIV_W(3), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_blank(wr_blank), .wr_dp(wr_dp),
        .wr_blink(wr_blink), .wr_valid(wr_valid), .wr_ready(wr_ready), .seg(seg), .an(an),
        .frame_pulse(frame_pulse));
`else
    seg7_scan_ctrl #(.SCAN_DIV(SD), .DIV_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_blank(wr_blank), .wr_dp(wr_dp),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .seg(seg), .an(an),
        .frame_pulse(frame_pulse));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: display content as a function of edges since reset release.
    int          e;
    bit          m_pend;
    bit          acc_ev;
    logic [31:0] m_ad, m_pd;
    logic [7:0]  m_ab, m_pb, m_adp, m_pdp, m_abk, m_pbk;
    logic [6:0]  gly [16];

    typedef struct {
        logic [31:0] d;
        logic [7:0]  b;
        logic [7:0]  dp;
        int          dig;
        logic [7:0]  es;
        logic [7:0]  ea;
    } vec_t;
    vec_t rows [7];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic model_reset();
        e = 0; m_pend = 0; acc_ev = 0;
        m_ad = '0; m_pd = '0; m_ab = '0; m_pb = '0;
        m_adp = '0; m_pdp = '0; m_abk = '0; m_pbk = '0;
    endtask

    task automatic step();
        int ip;
        bit dark;
        bit fb;
        logic [7:0] es, ea;
        @(posedge clk);
        e++;
        ip = ((e - 1) / SD) % 8;
        dark = m_ab[ip];
`ifdef SEG7_BLINK_EN
        if (((((e - 1) / FRAME) / BF) % 2) == 1 && m_abk[ip]) dark = 1;
`endif
        es = dark ? 8'hFF : ~{gly[m_ad[ip*4 +: 4]], m_adp[ip]};
        ea = dark ? 8'hFF : ~(8'b1 << ip);
        fb = (e % FRAME) == 0;
        acc_ev = 0;
        if (fb && m_pend) begin
            m_ad = m_pd; m_ab = m_pb; m_adp = m_pdp; m_abk = m_pbk; m_pend = 0;
        end else if (wr_valid && !m_pend) begin
            m_pd = wr_data; m_pb = wr_blank; m_pdp = wr_dp; m_pbk = wr_blink;
            m_pend = 1; acc_ev = 1;
        end
        #1;
        check8("seg", seg, es);
        check8("an", an, ea);
        check8("frame_pulse", {7'd0, frame_pulse}, {7'd0, fb});
        check8("wr_ready", {7'd0, wr_ready}, {7'd0, !m_pend});
    endtask

    task automatic write(input logic [31:0] d, input logic [7:0] b, input logic [7:0] dp,
                         input logic [7:0] bk);
        int n;
        wr_data = d; wr_blank = b; wr_dp = dp; wr_blink = bk; wr_valid = 1;
        n = 0;
        do begin step(); n++; end while (!acc_ev && n < 100);
        wr_valid = 0;
        check8("accept_timeout", {7'd0, acc_ev}, 8'd1);
        n = 0;
        while (m_pend && n < 100) begin step(); n++; end
    endtask

    task automatic reset_seq();
        rst_n = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check8("rst_seg", seg, 8'hFF);
            check8("rst_an", an, 8'hFF);
            check8("rst_fp", {7'd0, frame_pulse}, 8'd0);
            check8("rst_ready", {7'd0, wr_ready}, 8'd1);
        end
        rst_n = 1;
        model_reset();
    endtask

    initial begin
        gly = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        rows[0] = '{32'h89ABCDEF, 8'h00, 8'h00, 0, 8'h71, 8'hFE};
        rows[1] = '{32'h89ABCDEF, 8'h00, 8'h00, 1, 8'h61, 8'hFD};
        rows[2] = '{32'h89ABCDEF, 8'h00, 8'h00, 5, 8'h11, 8'hDF};
        rows[3] = '{32'h89ABCDEF, 8'h00, 8'h00, 7, 8'h01, 8'h7F};
        rows[4] = '{32'h89ABCDEF, 8'h80, 8'h01, 0, 8'h70, 8'hFE};
        rows[5] = '{32'h89ABCDEF, 8'h80, 8'h01, 3, 8'h63, 8'hF7};
        rows[6] = '{32'h89ABCDEF, 8'h80, 8'h01, 7, 8'hFF, 8'hFF};

        wr_data = '0; wr_blank = '0; wr_dp = '0; wr_blink = '0; wr_valid = 0;
        model_reset();
        reset_seq();

        // Idle display of zeros, including '0' on digit 0 right after release.
        for (int i = 0; i < 40; i++) step();

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            int n;
            if (i == 0 || rows[i].d != rows[i-1].d || rows[i].b != rows[i-1].b ||
                rows[i].dp != rows[i-1].dp)
                write(rows[i].d, rows[i].b, rows[i].dp, 8'h00);
            n = 0;
            while ((e % FRAME) != (4 * rows[i].dig + 2) && n < 64) begin step(); n++; end
            check8("tbl_seg", seg, rows[i].es);
            check8("tbl_an", an, rows[i].ea);
        end

        // Back-to-back writes with the second request held while not ready.
        begin
            int n;
            int fp_cnt;
            wr_data = 32'h01234567; wr_blank = 8'h00; wr_dp = 8'h00; wr_blink = 8'h00;
            wr_valid = 1;
            n = 0;
            do begin step(); n++; end while (!acc_ev && n < 100);
            wr_data = 32'hFEDCBA98; wr_dp = 8'hAA;
            n = 0;
            do begin step(); n++; end while (!acc_ev && n < 100);
            wr_valid = 0;
            check8("b2b_accept", {7'd0, acc_ev}, 8'd1);
            fp_cnt = 0;
            for (int i = 0; i < 3 * FRAME; i++) begin
                step();
                if (frame_pulse) fp_cnt++;
            end
            check8("fp_count", 8'(fp_cnt), 8'd3);
        end

        // Asynchronous reset in mid-frame with an update pending.
        begin
            int n;
            n = 0;
            while ((e % FRAME) != 10 && n < 64) begin step(); n++; end
            wr_data = 32'h55555555; wr_blank = 8'h00; wr_dp = 8'hFF; wr_valid = 1;
            step();
            wr_valid = 0;
            step();
            #2;
            rst_n = 0;
            #1;
            check8("arst_seg", seg, 8'hFF);
            check8("arst_an", an, 8'hFF);
            check8("arst_ready", {7'd0, wr_ready}, 8'd1);
            check8("arst_fp", {7'd0, frame_pulse}, 8'd0);
            reset_seq();
            for (int i = 0; i < 2 * FRAME + 4; i++) step();
        end

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if (!wr_valid && ($urandom % 5) == 0) begin
                wr_data  = $urandom;
                wr_blank = (($urandom % 3) == 0) ? 8'($urandom) : 8'h00;
                wr_dp    = 8'($urandom);
                wr_blink = 8'($urandom);
                wr_valid = 1;
            end
            step();
            if (acc_ev) wr_valid = 0;
        end
        wr_valid = 0;

`ifdef SEG7_BLINK_EN
        // Blink: digit 0 flagged, other digits steady.
        reset_seq();
        write(32'h00000000, 8'h00, 8'h00, 8'h01);
        for (int i = 0; i < 7 * FRAME; i++) step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
